// File: rtl/mem_seq_if_pkg.sv
// Shared definitions for the mem_seq_if memory block.
//   mem_state_e : controller states of the memory sequencer
//   WORD_BYTES  : bytes per memory word
//   idx_width() : word-index width for a given depth
package mem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } mem_state_e;

    localparam int unsigned WORD_BYTES = 4;

    function automatic int unsigned idx_width(input int unsigned depth_words);
        return $clog2(depth_words);
    endfunction

endpackage

// File: rtl/mem_seq_if_if.sv
// Request/ready bus between the multicycle controller/datapath and the memory.
//   master : controller side, drives MemReq/MemWrite/Adr/WriteData
//   slave  : memory side, drives ReadData/MemReady/AdrErr
interface mem_seq_if_if;

    logic        MemReq;
    logic        MemWrite;
    logic [31:0] Adr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        MemReady;
    logic        AdrErr;

    modport master (
        output MemReq,
        output MemWrite,
        output Adr,
        output WriteData,
        input  ReadData,
        input  MemReady,
        input  AdrErr
    );

    modport slave (
        input  MemReq,
        input  MemWrite,
        input  Adr,
        input  WriteData,
        output ReadData,
        output MemReady,
        output AdrErr
    );

endinterface

// File: rtl/mem_lat_counter.sv
// 4-bit loadable down-counter timing the memory wait states.
//   clk        : clock
//   reset      : synchronous active-high reset, clears the count
//   load_i     : load load_val_i (has priority over en_i)
//   load_val_i : value to load
//   en_i       : decrement by one (saturates at 0)
//   zero_o     : this enabled cycle takes the count from 1 to 0
module mem_lat_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       en_i,
    output logic       zero_o
);

    logic [3:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != 4'd0)) begin
            count_d = count_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // Flag the terminal decrement so the FSM can enter DONE on the same edge.
    assign zero_o = en_i && !load_i && (count_q == 4'd1);

endmodule

// File: rtl/mem_seq_if.sv
// Fixed-latency unified instruction/data memory with a request/ready handshake.
//   clk   : clock, all state on the rising edge
//   reset : synchronous active-high reset (array contents are kept)
//   bus   : slave side of mem_seq_if_if
//           MemReq/MemWrite/Adr/WriteData in, ReadData/MemReady/AdrErr out
// An accepted request completes LATENCY+1 cycles later with a one-cycle
// MemReady pulse; AdrErr flags a misaligned or out-of-range access.
module mem_seq_if
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned LATENCY     = 2
) (
    input logic              clk,
    input logic              reset,
    mem_seq_if_if.slave      bus
);

    localparam int unsigned IdxW      = idx_width(DEPTH_WORDS);
    localparam logic [31:0] SizeBytes = 32'(DEPTH_WORDS * WORD_BYTES);

    mem_state_e state_q, state_d;

    logic [31:0] adr_q, wdata_q;
    logic        we_q;
    logic        err_q;
    logic [31:0] read_data_q;

    logic [31:0] req_adr, req_wdata;
    logic        req_we, req_err;
    logic [IdxW-1:0] req_idx;
    logic        cnt_load, cnt_en, cnt_zero;
    logic        done_enter;

    logic [31:0] mem [DEPTH_WORDS];

    mem_lat_counter u_lat_counter (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (4'(LATENCY)),
        .en_i       (cnt_en),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.MemReq) begin
                    cnt_load = 1'b1;
                    state_d  = (LATENCY == 0) ? StDone : StWait;
                end
            end
            StWait: begin
                cnt_en = 1'b1;
                if (cnt_zero) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // With LATENCY=0 DONE is entered straight from IDLE, before the request
    // registers hold the access, so the live bus is used in that case.
    always_comb begin
        if (state_q == StIdle) begin
            req_adr   = bus.Adr;
            req_wdata = bus.WriteData;
            req_we    = bus.MemWrite;
        end else begin
            req_adr   = adr_q;
            req_wdata = wdata_q;
            req_we    = we_q;
        end
    end

    assign req_idx    = req_adr[IdxW+1:2];
    assign req_err    = (req_adr[1:0] != 2'b00) || (req_adr >= SizeBytes);
    assign done_enter = (state_d == StDone) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            adr_q       <= 32'd0;
            wdata_q     <= 32'd0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            read_data_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if ((state_q == StIdle) && bus.MemReq) begin
                adr_q   <= bus.Adr;
                wdata_q <= bus.WriteData;
                we_q    <= bus.MemWrite;
            end
            if (done_enter) begin
                err_q <= req_err;
                if (req_err) begin
                    read_data_q <= 32'd0;
                end else if (!req_we) begin
                    read_data_q <= mem[req_idx];
                end
            end
        end
    end

    // No reset: contents survive reset, and done_enter already blocks writes under reset.
    always_ff @(posedge clk) begin
        if (done_enter && req_we && !req_err) begin
            mem[req_idx] <= req_wdata;
        end
    end

    assign bus.MemReady = (state_q == StDone);
    assign bus.AdrErr   = (state_q == StDone) && err_q;
    assign bus.ReadData = read_data_q;

endmodule

// File: tb/tb_mem_seq_if.sv
// Self-checking bench for mem_seq_if: a LATENCY=2 instance driven by a vector
// table plus hand sequences, and a LATENCY=0 instance with MemReq held high.
module tb_mem_seq_if;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_seq_if_if bus2();
    mem_seq_if_if bus0();

    mem_seq_if #(.DEPTH_WORDS(64), .LATENCY(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    mem_seq_if #(.DEPTH_WORDS(64), .LATENCY(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[12];

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } op_t;

    op_t ops0[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One handshake on the LATENCY=2 instance; starts and ends at a falling edge.
    task automatic access(input logic we, input logic [31:0] adr, input logic [31:0] wdata,
                          input logic toggle, output int lat, output logic err,
                          output logic [31:0] rd);
        bus2.MemReq    = 1'b1;
        bus2.MemWrite  = we;
        bus2.Adr       = adr;
        bus2.WriteData = wdata;
        lat = 0;
        err = 1'b0;
        rd  = 32'd0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus2.MemReady) begin
                lat = k;
                err = bus2.AdrErr;
                rd  = bus2.ReadData;
                break;
            end
            if (toggle) begin
                bus2.Adr       = $urandom;
                bus2.WriteData = $urandom;
            end
        end
        bus2.MemReq = 1'b0;
        @(negedge clk);
        chk("ready_one_cycle", {31'd0, bus2.MemReady}, 32'd0);
    endtask

    int          lat;
    logic        err;
    logic [31:0] rd;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 32'h0,        32'hA5A5A5A5, 1'b0, 32'hDEADBEEF};
        vecs[3]  = '{1'b0, 32'h13,       32'h0,        1'b1, 32'h0};
        vecs[4]  = '{1'b1, 32'h102,      32'h0BADBAD0, 1'b1, 32'h0};
        vecs[5]  = '{1'b0, 32'h0,        32'h0,        1'b0, 32'hA5A5A5A5};
        vecs[6]  = '{1'b1, 32'hFC,       32'hCAFEF00D, 1'b0, 32'hA5A5A5A5};
        vecs[7]  = '{1'b0, 32'hFC,       32'h0,        1'b0, 32'hCAFEF00D};
        vecs[8]  = '{1'b0, 32'h100,      32'h0,        1'b1, 32'h0};
        vecs[9]  = '{1'b1, 32'h8,        32'h11112222, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 32'h8,        32'h0,        1'b0, 32'h11112222};
        vecs[11] = '{1'b0, 32'hFFFFFFFC, 32'h0,        1'b1, 32'h0};

        ops0[0] = '{1'b1, 32'h4, 32'h0BADF00D, 32'h0};
        ops0[1] = '{1'b1, 32'h8, 32'h600DCAFE, 32'h0};
        ops0[2] = '{1'b0, 32'h4, 32'h0,        32'h0BADF00D};
        ops0[3] = '{1'b0, 32'h8, 32'h0,        32'h600DCAFE};
        ops0[4] = '{1'b0, 32'h4, 32'h0,        32'h0BADF00D};
        ops0[5] = '{1'b0, 32'h8, 32'h0,        32'h600DCAFE};

        reset = 1'b1;
        bus2.MemReq = 1'b0; bus2.MemWrite = 1'b0; bus2.Adr = '0; bus2.WriteData = '0;
        bus0.MemReq = 1'b0; bus0.MemWrite = 1'b0; bus0.Adr = '0; bus0.WriteData = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Idle after reset: all outputs low.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_ready", {31'd0, bus2.MemReady}, 32'd0);
            chk("idle_err",   {31'd0, bus2.AdrErr},   32'd0);
            chk("idle_rdata", bus2.ReadData,          32'd0);
        end

        // Vector table.
        for (int i = 0; i < 12; i++) begin
            access(vecs[i].we, vecs[i].adr, vecs[i].wdata, 1'b0, lat, err, rd);
            chk($sformatf("vec%0d_latency", i), lat,           32'd3);
            chk($sformatf("vec%0d_err", i),     {31'd0, err},  {31'd0, vecs[i].exp_err});
            chk($sformatf("vec%0d_rdata", i),   rd,            vecs[i].exp_rd);
        end

        // Read data holds across idle cycles.
        access(1'b0, 32'h10, 32'h0, 1'b0, lat, err, rd);
        chk("hold_first", rd, 32'hDEADBEEF);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_rdata", bus2.ReadData, 32'hDEADBEEF);
        end

        // Bus inputs toggling during WAIT must not disturb the latched write.
        access(1'b1, 32'h20, 32'h12345678, 1'b1, lat, err, rd);
        chk("toggle_wr_latency", lat, 32'd3);
        chk("toggle_wr_err", {31'd0, err}, 32'd0);
        access(1'b0, 32'h20, 32'h0, 1'b0, lat, err, rd);
        chk("toggle_rd_data", rd, 32'h12345678);

        // Reset during WAIT abandons the write and clears outputs.
        access(1'b0, 32'h8, 32'h0, 1'b0, lat, err, rd);
        chk("pre_reset_rdata", rd, 32'h11112222);
        bus2.MemReq = 1'b1; bus2.MemWrite = 1'b1;
        bus2.Adr = 32'h8;   bus2.WriteData = 32'h55AA55AA;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'd0, bus2.MemReady}, 32'd0);
        chk("rst_err",   {31'd0, bus2.AdrErr},   32'd0);
        chk("rst_rdata", bus2.ReadData,          32'd0);
        bus2.MemReq = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        access(1'b0, 32'h8, 32'h0, 1'b0, lat, err, rd);
        chk("post_rst_latency", lat, 32'd3);
        chk("post_rst_rdata",   rd,  32'h11112222);

        // LATENCY=0 with MemReq held high: a pulse every second cycle.
        bus0.MemReq    = 1'b1;
        bus0.MemWrite  = ops0[0].we;
        bus0.Adr       = ops0[0].adr;
        bus0.WriteData = ops0[0].wdata;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("l0_op%0d_ready", i), {31'd0, bus0.MemReady}, 32'd1);
            chk($sformatf("l0_op%0d_err", i),   {31'd0, bus0.AdrErr},   32'd0);
            if (!ops0[i].we) begin
                chk($sformatf("l0_op%0d_rdata", i), bus0.ReadData, ops0[i].exp_rd);
            end
            if (i < 5) begin
                bus0.MemWrite  = ops0[i+1].we;
                bus0.Adr       = ops0[i+1].adr;
                bus0.WriteData = ops0[i+1].wdata;
            end
            @(negedge clk);
            chk($sformatf("l0_op%0d_gap", i), {31'd0, bus0.MemReady}, 32'd0);
        end
        bus0.MemReq = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
